cmsdk_ahb_copy_master: RTL and testbench

//  AHB-Lite initiator (bus master) that copies a block of 32-bit words from a source address to a destination address.
//  It is the initiator end of the same AHB-Lite interface the ROM/RAM responders serve.

---
 rtl/cmsdk_ahb_copy_master.sv | 161 ++++++++++++++++
 tb/tb_cmsdk_ahb_copy_master.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmsdk_ahb_copy_master.sv
// cmsdk_ahb_copy_master
// AHB-Lite initiator that copies a block of 32-bit words from a source to a
// destination address. Every word costs one non-pipelined read (address phase,
// then data phase) followed by one non-pipelined write. The master never
// overlaps an address phase with a data phase, so HTRANS is IDLE during every
// data phase. Completion and bus errors are reported by one-cycle pulses.
// err_addr keeps the faulting address until the next accepted start.
module cmsdk_ahb_copy_master #(
    parameter int LEN_W = 16
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      err_addr,
    output logic [31:0]      HADDR,
    output logic [1:0]       HTRANS,
    output logic [2:0]       HSIZE,
    output logic             HWRITE,
    output logic [31:0]      HWDATA,
    input  logic             HREADY,
    input  logic [31:0]      HRDATA,
    input  logic             HRESP
);

    // FSM encoding
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RA   = 3'd1;   // read address phase
    localparam logic [2:0] S_RD   = 3'd2;   // read data phase
    localparam logic [2:0] S_WA   = 3'd3;   // write address phase
    localparam logic [2:0] S_WD   = 3'd4;   // write data phase
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    localparam logic [1:0]  TRANS_IDLE   = 2'b00;
    localparam logic [1:0]  TRANS_NONSEQ = 2'b10;
    localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;

    logic [2:0]       state_reg;
    logic [31:0]      src_ptr_reg;
    logic [31:0]      dst_ptr_reg;
    logic [LEN_W-1:0] remain_reg;
    logic [31:0]      data_reg;

    // Only word transfers are issued.
    assign HSIZE  = 3'b010;
    // Write data comes straight from the holding register, so it is stable
    // for the whole write data phase including wait states.
    assign HWDATA = data_reg;

    // Copy sequencer: FSM, pointers, word counter and all registered bus/status outputs.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_reg   <= S_IDLE;
            src_ptr_reg <= '0;
            dst_ptr_reg <= '0;
            remain_reg  <= '0;
            data_reg    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_addr    <= '0;
            HADDR       <= '0;
            HTRANS      <= TRANS_IDLE;
            HWRITE      <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses unless re-asserted below.
            done  <= 1'b0;
            error <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        err_addr <= '0;
                        if (len != '0) begin
                            src_ptr_reg <= src_addr & WORD_MASK;
                            dst_ptr_reg <= dst_addr & WORD_MASK;
                            remain_reg  <= len;
                            HADDR       <= src_addr & WORD_MASK;
                            HTRANS      <= TRANS_NONSEQ;
                            HWRITE      <= 1'b0;
                            state_reg   <= S_RA;
                        end else begin
                            // Empty block: report completion without touching the bus.
                            done      <= 1'b1;
                            state_reg <= S_DONE;
                        end
                    end
                end
                S_RA: begin
                    // Address-phase signals are simply held while HREADY is low.
                    if (HREADY) begin
                        HTRANS    <= TRANS_IDLE;
                        state_reg <= S_RD;
                    end
                end
                S_RD: begin
                    if (HREADY) begin
                        if (HRESP) begin
                            err_addr  <= src_ptr_reg;
                            error     <= 1'b1;
                            state_reg <= S_ERR;
                        end else begin
                            data_reg  <= HRDATA;
                            HADDR     <= dst_ptr_reg;
                            HTRANS    <= TRANS_NONSEQ;
                            HWRITE    <= 1'b1;
                            state_reg <= S_WA;
                        end
                    end
                end
                S_WA: begin
                    if (HREADY) begin
                        HTRANS    <= TRANS_IDLE;
                        state_reg <= S_WD;
                    end
                end
                S_WD: begin
                    if (HREADY) begin
                        if (HRESP) begin
                            err_addr  <= dst_ptr_reg;
                            error     <= 1'b1;
                            HWRITE    <= 1'b0;
                            state_reg <= S_ERR;
                        end else begin
                            // Pointers wrap naturally modulo 2^32.
                            src_ptr_reg <= src_ptr_reg + 32'd4;
                            dst_ptr_reg <= dst_ptr_reg + 32'd4;
                            remain_reg  <= remain_reg - LEN_W'(1);
                            HWRITE      <= 1'b0;
                            if (remain_reg == LEN_W'(1)) begin
                                done      <= 1'b1;
                                state_reg <= S_DONE;
                            end else begin
                                HADDR     <= src_ptr_reg + 32'd4;
                                HTRANS    <= TRANS_NONSEQ;
                                state_reg <= S_RA;
                            end
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    HTRANS    <= TRANS_IDLE;
                    HWRITE    <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmsdk_ahb_copy_master.sv
// tb_cmsdk_ahb_copy_master
// Drives copy requests into the master, plays an AHB-Lite memory slave with
// optional wait states and ERROR responses, and scores every completed bus
// transfer against an expected-transfer queue filled when each copy is started.
module tb_cmsdk_ahb_copy_master;

    localparam int         LEN_W    = 16;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;

    logic             HCLK = 1'b0;
    logic             HRESET;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             error;
    logic [31:0]      err_addr;
    logic [31:0]      HADDR;
    logic [1:0]       HTRANS;
    logic [2:0]       HSIZE;
    logic             HWRITE;
    logic [31:0]      HWDATA;
    logic             HREADY;
    logic [31:0]      HRDATA;
    logic             HRESP;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] data;
        logic        err;
    } xfer_t;

    typedef struct {
        int done_d;
        int err_d;
        int done_cnt;
        int err_cnt;
        int busy_cyc;
        int writes;
        int nonseq_cnt;
        int nonseq_after_err;
    } res_t;

    xfer_t       exp_q[$];
    xfer_t       obs_q[$];
    logic [31:0] mem [logic [31:0]];

    // Slave configuration and data-phase tracking
    int          wait_cfg     = 0;
    bit          err_en       = 1'b0;
    logic [31:0] err_inj_addr = '0;
    bit          pend         = 1'b0;
    logic        p_write      = 1'b0;
    bit          p_err        = 1'b0;
    logic [31:0] p_addr       = '0;
    int          wait_left    = 0;
    int          err_stage    = 0;

    cmsdk_ahb_copy_master #(.LEN_W(LEN_W)) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_addr (err_addr),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HSIZE    (HSIZE),
        .HWRITE   (HWRITE),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .HRDATA   (HRDATA),
        .HRESP    (HRESP)
    );

    initial forever #5 HCLK = ~HCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // Memory slave: decides HREADY/HRESP/HRDATA for the current cycle at the falling edge.
    initial begin
        xfer_t t;
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        forever begin
            @(negedge HCLK);
            if (HRESET) begin
                pend   = 1'b0;
                HREADY = 1'b1;
                HRESP  = 1'b0;
            end else begin
                if (pend) begin
                    if (p_err && err_stage == 0) begin
                        HREADY    = 1'b0;
                        HRESP     = 1'b1;
                        err_stage = 1;
                    end else if (p_err) begin
                        HREADY = 1'b1;
                        HRESP  = 1'b1;
                        t.addr = p_addr; t.write = p_write; t.data = '0; t.err = 1'b1;
                        obs_q.push_back(t);
                        pend = 1'b0;
                    end else if (wait_left > 0) begin
                        HREADY = 1'b0;
                        HRESP  = 1'b0;
                        wait_left--;
                    end else begin
                        HREADY = 1'b1;
                        HRESP  = 1'b0;
                        if (p_write) begin
                            mem[p_addr] = HWDATA;
                            t.data = HWDATA;
                        end else begin
                            HRDATA = mem.exists(p_addr) ? mem[p_addr] : 32'h0;
                            t.data = HRDATA;
                        end
                        t.addr = p_addr; t.write = p_write; t.err = 1'b0;
                        obs_q.push_back(t);
                        pend = 1'b0;
                    end
                end else begin
                    HREADY = 1'b1;
                    HRESP  = 1'b0;
                end
                if (!pend && HREADY && HTRANS == T_NONSEQ) begin
                    pend      = 1'b1;
                    p_addr    = HADDR;
                    p_write   = HWRITE;
                    wait_left = wait_cfg;
                    p_err     = err_en && !HWRITE && (HADDR == err_inj_addr);
                    err_stage = 0;
                end
            end
        end
    end

    // Starts one copy, then observes cycle d = 1,2,... after the start cycle,
    // scoring transfers as the slave completes them.
    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int n,
                            input int waits, input bit inj, input logic [31:0] inj_addr,
                            input int mid_d, output res_t r);
        logic [31:0] a;
        xfer_t       e;
        xfer_t       o;
        logic [31:0] prev_haddr;
        logic        prev_hwrite;
        logic [31:0] prev_hwdata;
        logic        prev_hready;
        int          end_d;
        wait_cfg = waits; err_en = inj; err_inj_addr = inj_addr;
        exp_q.delete(); obs_q.delete();
        r = '{-1, -1, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < n; i++) begin
            a = src + 32'(4 * i);
            mem[a] = $urandom;
        end
        for (int i = 0; i < n; i++) begin
            a = src + 32'(4 * i);
            e.addr = a; e.write = 1'b0; e.data = mem[a]; e.err = inj && (a == inj_addr);
            exp_q.push_back(e);
            if (e.err) break;
            e.addr = dst + 32'(4 * i); e.write = 1'b1; e.data = mem[a]; e.err = 1'b0;
            exp_q.push_back(e);
        end
        @(negedge HCLK); #2;
        src_addr = src; dst_addr = dst; len = LEN_W'(n); start = 1'b1;
        @(negedge HCLK); #2;
        start = 1'b0; src_addr = 32'hDEAD_BEE0; dst_addr = 32'h5A5A_0000; len = LEN_W'(7);
        prev_hready = 1'b1; prev_haddr = HADDR; prev_hwrite = HWRITE; prev_hwdata = HWDATA;
        end_d = -1;
        for (int d = 1; d <= 400; d++) begin
            if (d > 1) begin @(negedge HCLK); #2; end
            start = (d == mid_d);
            if (done) begin r.done_cnt++; if (r.done_d < 0) r.done_d = d; end
            if (error) begin r.err_cnt++; if (r.err_d < 0) r.err_d = d; end
            if (busy) r.busy_cyc++;
            if (HTRANS == T_NONSEQ) begin
                r.nonseq_cnt++;
                if (r.err_d >= 0) r.nonseq_after_err++;
            end
            if (!prev_hready) begin
                checks++;
                if (HADDR !== prev_haddr || HWRITE !== prev_hwrite || HWDATA !== prev_hwdata) begin
                    failures++;
                    $display("FAIL hold_during_wait cycle %0d: HADDR=%h HWRITE=%b HWDATA=%h, required %h %b %h",
                             d, HADDR, HWRITE, HWDATA, prev_haddr, prev_hwrite, prev_hwdata);
                end
            end
            prev_hready = HREADY; prev_haddr = HADDR; prev_hwrite = HWRITE; prev_hwdata = HWDATA;
            while (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                if (o.write) r.writes++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_extra: got addr=%h write=%b data=%h err=%b, required no transfer",
                             o.addr, o.write, o.data, o.err);
                end else begin
                    e = exp_q.pop_front();
                    if (o.addr !== e.addr || o.write !== e.write || o.err !== e.err ||
                        (e.write && o.data !== e.data)) begin
                        failures++;
                        $display("FAIL scoreboard_xfer: got addr=%h write=%b data=%h err=%b, required addr=%h write=%b data=%h err=%b",
                                 o.addr, o.write, o.data, o.err, e.addr, e.write, e.data, e.err);
                    end
                end
            end
            if (end_d < 0 && (r.done_d >= 0 || r.err_d >= 0)) end_d = d;
            if (end_d >= 0 && d >= end_d + 3) break;
        end
        start = 1'b0;
        checks++;
        if (end_d < 0) begin
            failures++;
            $display("FAIL copy_timeout: no done/error within 400 cycles, required one");
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_missing: %0d transfers never seen, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        HRESET = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        repeat (2) @(negedge HCLK);
        #2;
        checks++;
        if (HADDR !== 32'h0 || HTRANS !== T_IDLE || HWRITE !== 1'b0 || HWDATA !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus: HADDR=%h HTRANS=%b HWRITE=%b HWDATA=%h, required 0 00 0 0",
                     HADDR, HTRANS, HWRITE, HWDATA);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || err_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_status: busy=%b done=%b error=%b err_addr=%h, required 0 0 0 0",
                     busy, done, error, err_addr);
        end
        checks++;
        if (HSIZE !== 3'b010) begin
            failures++;
            $display("FAIL hsize: got %b, required 010", HSIZE);
        end
        HRESET = 1'b0;
        repeat (3) @(negedge HCLK);
        #2;
        checks++;
        if (HTRANS !== T_IDLE || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: HTRANS=%b busy=%b, required 00 0", HTRANS, busy);
        end
    endtask

    task automatic test_copy_zero_wait();
        res_t r;
        run_copy(32'h0000_0100, 32'h2000_0000, 4, 0, 1'b0, 32'h0, -1, r);
        checks++;
        if (r.done_d !== 17 || r.done_cnt !== 1) begin
            failures++;
            $display("FAIL zw_done: at cycle %0d count %0d, required cycle 17 count 1", r.done_d, r.done_cnt);
        end
        checks++;
        if (r.busy_cyc !== 17) begin
            failures++;
            $display("FAIL zw_busy: busy for %0d cycles, required 17", r.busy_cyc);
        end
        checks++;
        if (r.err_cnt !== 0 || r.writes !== 4) begin
            failures++;
            $display("FAIL zw_counts: errors=%0d writes=%0d, required 0 4", r.err_cnt, r.writes);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[32'h2000_0000 + 32'(4 * i)] !== mem[32'h0000_0100 + 32'(4 * i)]) begin
                failures++;
                $display("FAIL zw_dst_word%0d: got %h, required %h", i,
                         mem[32'h2000_0000 + 32'(4 * i)], mem[32'h0000_0100 + 32'(4 * i)]);
            end
        end
    endtask

    task automatic test_wait_states();
        res_t r;
        // One wait state in every data phase: two extra cycles per word.
        run_copy(32'h0000_0100, 32'h2000_0000, 4, 1, 1'b0, 32'h0, -1, r);
        checks++;
        if (r.done_d !== 25 || r.done_cnt !== 1) begin
            failures++;
            $display("FAIL ws_done: at cycle %0d count %0d, required cycle 25 count 1", r.done_d, r.done_cnt);
        end
        checks++;
        if (r.writes !== 4 || mem[32'h2000_000C] !== mem[32'h0000_010C]) begin
            failures++;
            $display("FAIL ws_data: writes=%0d last dst=%h, required 4 %h",
                     r.writes, mem[32'h2000_000C], mem[32'h0000_010C]);
        end
    endtask

    task automatic test_read_error();
        res_t r;
        run_copy(32'h0000_0100, 32'h2000_0000, 4, 0, 1'b1, 32'h0000_0108, -1, r);
        checks++;
        if (r.err_cnt !== 1 || r.err_d !== 12) begin
            failures++;
            $display("FAIL err_pulse: count %0d at cycle %0d, required count 1 at cycle 12", r.err_cnt, r.err_d);
        end
        checks++;
        if (err_addr !== 32'h0000_0108) begin
            failures++;
            $display("FAIL err_addr: got %h, required 00000108", err_addr);
        end
        checks++;
        if (r.writes !== 2 || r.nonseq_after_err !== 0 || r.done_cnt !== 0) begin
            failures++;
            $display("FAIL err_abort: writes=%0d nonseq_after=%0d done=%0d, required 2 0 0",
                     r.writes, r.nonseq_after_err, r.done_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL err_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_zero_len();
        res_t r;
        run_copy(32'h0000_0200, 32'h2000_0100, 0, 0, 1'b0, 32'h0, -1, r);
        checks++;
        if (r.done_d !== 1 || r.done_cnt !== 1 || r.busy_cyc !== 1) begin
            failures++;
            $display("FAIL zero_len_done: cycle %0d count %0d busy %0d, required 1 1 1",
                     r.done_d, r.done_cnt, r.busy_cyc);
        end
        checks++;
        if (r.nonseq_cnt !== 0 || r.err_cnt !== 0) begin
            failures++;
            $display("FAIL zero_len_bus: nonseq=%0d errors=%0d, required 0 0", r.nonseq_cnt, r.err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        res_t r;
        // Second start pulse at cycle 6 while the first copy is running.
        run_copy(32'h0000_0300, 32'h2000_0200, 3, 0, 1'b0, 32'h0, 6, r);
        checks++;
        if (r.done_d !== 13 || r.done_cnt !== 1) begin
            failures++;
            $display("FAIL ignore_start_done: cycle %0d count %0d, required 13 1", r.done_d, r.done_cnt);
        end
        checks++;
        if (r.writes !== 3 || r.nonseq_cnt !== 6 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start_bus: writes=%0d nonseq=%0d busy=%b, required 3 6 0",
                     r.writes, r.nonseq_cnt, busy);
        end
    endtask

    task automatic test_reset_mid_write();
        bit seen = 1'b0;
        wait_cfg = 0; err_en = 1'b0;
        exp_q.delete(); obs_q.delete();
        @(negedge HCLK); #2;
        src_addr = 32'h0000_0400; dst_addr = 32'h0000_0500; len = LEN_W'(4); start = 1'b1;
        @(negedge HCLK); #2;
        start = 1'b0;
        for (int d = 0; d < 40; d++) begin
            if (HTRANS == T_NONSEQ && HWRITE) begin seen = 1'b1; break; end
            @(negedge HCLK); #2;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL wa_timeout: no write address phase in 40 cycles, required one");
        end
        HRESET = 1'b1;
        #1;
        checks++;
        if (HTRANS !== T_IDLE || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_wa: HTRANS=%b busy=%b, required 00 0", HTRANS, busy);
        end
        pend = 1'b0;
        @(negedge HCLK); #2;
        HRESET = 1'b0;
        for (int d = 0; d < 6; d++) begin
            @(negedge HCLK); #2;
            checks++;
            if (HTRANS !== T_IDLE || busy !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL stay_idle cycle %0d: HTRANS=%b busy=%b done=%b, required 00 0 0",
                         d, HTRANS, busy, done);
            end
        end
        obs_q.delete();
    endtask

    task automatic test_wrap();
        res_t r;
        run_copy(32'hFFFF_FFFC, 32'h3000_0000, 2, 0, 1'b0, 32'h0, -1, r);
        checks++;
        if (r.done_d !== 9 || r.done_cnt !== 1 || r.writes !== 2) begin
            failures++;
            $display("FAIL wrap_done: cycle %0d count %0d writes %0d, required 9 1 2",
                     r.done_d, r.done_cnt, r.writes);
        end
        checks++;
        if (mem[32'h3000_0004] !== mem[32'h0000_0000]) begin
            failures++;
            $display("FAIL wrap_data: dst word1=%h, required %h", mem[32'h3000_0004], mem[32'h0000_0000]);
        end
    endtask

    initial begin
        test_reset();
        test_copy_zero_wait();
        test_wait_states();
        test_read_error();
        test_zero_len();
        test_back_to_back();
        test_reset_mid_write();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
